// File: rtl/ro_pkg.sv
// ----------------------------------------------------------------------------
// ro_pkg
// Shared definitions for the multi-channel readout arbiter:
//   - frame marker nibbles for header and trailer words
//   - FSM state encoding
//   - field positions inside the 16-bit frame field that is left-justified
//     in every header/trailer word (lower bits are zero padding when DW > 16)
//   - helpers that build the header and trailer frame fields
// ----------------------------------------------------------------------------
package ro_pkg;

  localparam logic [3:0] HDR_MARK = 4'hA;
  localparam logic [3:0] TRL_MARK = 4'hE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    READ    = 2'd2,
    TRAILER = 2'd3
  } state_t;

  // Frame field layout (bit positions within the 16-bit field).
  localparam int FRAME_W    = 16;
  localparam int MARK_LSB   = 12;
  localparam int MARK_W     = 4;
  localparam int HDR_CH_LSB = 0;
  localparam int HDR_CH_W   = 8;
  localparam int TRL_CNT_LSB = 0;
  localparam int TRL_CNT_W   = 12;

  // Burst word counter width; large enough for the maximum burst of 4095.
  localparam int CNT_W = 12;

  function automatic logic [FRAME_W-1:0] hdr_field(input logic [HDR_CH_W-1:0] ch);
    hdr_field = '0;
    hdr_field[MARK_LSB +: MARK_W]     = HDR_MARK;
    hdr_field[HDR_CH_LSB +: HDR_CH_W] = ch;
  endfunction

  function automatic logic [FRAME_W-1:0] trl_field(input logic [TRL_CNT_W-1:0] cnt);
    trl_field = '0;
    trl_field[MARK_LSB +: MARK_W]       = TRL_MARK;
    trl_field[TRL_CNT_LSB +: TRL_CNT_W] = cnt;
  endfunction

endpackage

// File: rtl/ro_channel_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Returns the first requesting
// index found searching upward from ptr, wrapping modulo NCH.
// Ports:
//   req   in  NCH   request vector
//   ptr   in  CH_W  search start index (always < NCH)
//   idx   out CH_W  picked index (0 when nothing is requested)
//   valid out 1     at least one request is set
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] idx,
  output logic            valid
);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!valid && req[(int'(ptr) + k) % NCH]) begin
        valid = 1'b1;
        idx   = CH_W'((int'(ptr) + k) % NCH);
      end
    end
  end

endmodule

// File: rtl/ro_channel_arbiter.sv
// ----------------------------------------------------------------------------
// ro_channel_arbiter
// Round-robin scheduler sharing one output-FIFO write port between NCH
// show-ahead channel FIFOs. Each grant emits a frame: header word, up to
// MAX_BURST data words popped from the granted channel, then a trailer word
// carrying the data word count.
// Ports:
//   CLK        in  1       system clock
//   RST        in  1       synchronous, active-high reset
//   DAVAIL     in  NCH     per-channel FIFO non-empty
//   CH_DATA    in  NCH*DW  per-channel head word, channel i at [i*DW +: DW]
//   CH_RDEN    out NCH     one-hot pop strobe (combinational)
//   FIFO_FULL  in  1       output FIFO full
//   WR_EN      out 1       registered output FIFO write strobe
//   WR_DATA    out DW      registered output FIFO write data
//   CHSEL      out CH_W    registered index of the granted channel
//   BUSY       out 1       registered, high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module ro_channel_arbiter
  import ro_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 64,
  parameter int CH_W      = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH-1:0]    DAVAIL,
  input  logic [NCH*DW-1:0] CH_DATA,
  output logic [NCH-1:0]    CH_RDEN,
  input  logic              FIFO_FULL,
  output logic              WR_EN,
  output logic [DW-1:0]     WR_DATA,
  output logic [CH_W-1:0]   CHSEL,
  output logic              BUSY
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   chsel_d;
  logic              wr_en_d;
  logic [DW-1:0]     wr_data_d;

  logic [CH_W-1:0]   pick_idx;
  logic              pick_valid;
  logic              sel_avail;
  logic [DW-1:0]     sel_data;
  logic              pop;
  logic [CNT_W-1:0]  cnt_inc;

  // Header/trailer fields sit in the top 16 bits; wider words pad below.
  function automatic logic [DW-1:0] frame_word(input logic [FRAME_W-1:0] f);
    frame_word = '0;
    frame_word[DW-1 -: FRAME_W] = f;
  endfunction

  rr_pick #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_rr_pick (
    .req   (DAVAIL),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign sel_avail = DAVAIL[CHSEL];
  assign sel_data  = CH_DATA[int'(CHSEL)*DW +: DW];
  assign cnt_inc   = cnt_q + 1'b1;

  // Pop is suppressed during reset so no word is consumed that the reset
  // would then drop on the floor.
  assign pop = (state_q == READ) && sel_avail && !FIFO_FULL &&
               (cnt_q < MAX_CNT) && !RST;

  // State and output registers.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous here: it is just the highest-priority branch
    // sampled on the clock edge, not part of the sensitivity list.
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      CHSEL   <= '0;
      WR_EN   <= 1'b0;
      WR_DATA <= '0;
      BUSY    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of every other register.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      CHSEL   <= chsel_d;
      WR_EN   <= wr_en_d;
      WR_DATA <= wr_data_d;
      BUSY    <= (state_d != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = HEADER;
      HEADER:  if (!FIFO_FULL) state_d = READ;
      READ: begin
        if (!sel_avail)                          state_d = TRAILER;
        else if (pop && (cnt_inc == MAX_CNT))    state_d = TRAILER;
        else if (!pop && (cnt_q >= MAX_CNT))     state_d = TRAILER;
      end
      TRAILER: if (!FIFO_FULL) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    CH_RDEN   = '0;
    wr_en_d   = 1'b0;
    wr_data_d = WR_DATA;
    chsel_d   = CHSEL;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          chsel_d = pick_idx;
          cnt_d   = '0;
        end
      end
      HEADER: begin
        if (!FIFO_FULL) begin
          wr_en_d   = 1'b1;
          wr_data_d = frame_word(hdr_field(HDR_CH_W'(CHSEL)));
        end
      end
      READ: begin
        if (pop) begin
          CH_RDEN[CHSEL] = 1'b1;
          wr_en_d        = 1'b1;
          wr_data_d      = sel_data;
          cnt_d          = cnt_inc;
        end
      end
      TRAILER: begin
        if (!FIFO_FULL) begin
          wr_en_d   = 1'b1;
          wr_data_d = frame_word(trl_field(cnt_q[TRL_CNT_W-1:0]));
          rr_d      = (CHSEL == CH_W'(NCH - 1)) ? '0 : CHSEL + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ro_channel_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ro_channel_arbiter
// Directed bench: per-channel show-ahead FIFOs are modelled with queues, every
// output FIFO write is logged and compared against hand-computed frames.
// MAX_BURST is 4 so the burst limit is reached with short stimulus.
// ----------------------------------------------------------------------------
module tb_ro_channel_arbiter;
  import ro_pkg::*;

  localparam int NCH       = 4;
  localparam int DW        = 16;
  localparam int MAX_BURST = 4;
  localparam int CH_W      = 2;

  typedef logic [DW-1:0] wq_t [$];

  logic              CLK = 1'b0;
  logic              RST;
  logic [NCH-1:0]    DAVAIL;
  logic [NCH*DW-1:0] CH_DATA;
  logic [NCH-1:0]    CH_RDEN;
  logic              FIFO_FULL;
  logic              WR_EN;
  logic [DW-1:0]     WR_DATA;
  logic [CH_W-1:0]   CHSEL;
  logic              BUSY;

  always #5 CLK = ~CLK;

  ro_channel_arbiter #(
    .NCH       (NCH),
    .DW        (DW),
    .MAX_BURST (MAX_BURST),
    .CH_W      (CH_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DAVAIL    (DAVAIL),
    .CH_DATA   (CH_DATA),
    .CH_RDEN   (CH_RDEN),
    .FIFO_FULL (FIFO_FULL),
    .WR_EN     (WR_EN),
    .WR_DATA   (WR_DATA),
    .CHSEL     (CHSEL),
    .BUSY      (BUSY)
  );

  logic [DW-1:0]  chq [NCH][$];
  wq_t            wlog;
  logic [NCH-1:0] last_rd;
  int             total = 0;
  int             bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NCH; i++) begin
      DAVAIL[i] = (chq[i].size() != 0);
      CH_DATA[i*DW +: DW] = (chq[i].size() != 0) ? chq[i][0] : '0;
    end
  endtask

  // One clock cycle: sample pop strobe before the edge, pop the model FIFOs
  // just after it, then log any write visible at the following negedge.
  task automatic tick();
    logic [NCH-1:0] rd;
    logic           full_now;
    #1;
    rd       = CH_RDEN;
    full_now = FIFO_FULL;
    if (rd != '0) begin
      check("rden_while_full", 32'(full_now), 32'd0);
      check("rden_granted", 32'(rd), 32'd1 << CHSEL);
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < NCH; i++)
      if (rd[i] && chq[i].size() != 0) void'(chq[i].pop_front());
    refresh();
    @(negedge CLK);
    last_rd = rd;
    if (WR_EN) begin
      wlog.push_back(WR_DATA);
      check("wr_while_full", 32'(full_now), 32'd0);
    end
  endtask

  task automatic expect_log(input string tag, input wq_t e);
    check($sformatf("%s_len", tag), 32'(wlog.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < wlog.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(wlog[i]), 32'(e[i]));
    wlog.delete();
  endtask

  initial begin
    wq_t            e;
    logic           seen;
    logic [NCH-1:0] rd_acc;
    int             pops;

    RST       = 1'b1;
    FIFO_FULL = 1'b0;
    DAVAIL    = '0;
    CH_DATA   = '0;
    last_rd   = '0;
    refresh();

    // Reset values.
    repeat (3) tick();
    check("rst_wr_en",   32'(WR_EN),    32'd0);
    check("rst_wr_data", 32'(WR_DATA),  32'd0);
    check("rst_chsel",   32'(CHSEL),    32'd0);
    check("rst_busy",    32'(BUSY),     32'd0);
    check("rst_rr",      32'(dut.rr_q), 32'd0);
    RST = 1'b0;

    // Idle: nothing requested for 20 cycles.
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | WR_EN | BUSY | (|CH_RDEN);
    end
    check("idle_quiet", 32'(seen), 32'd0);
    check("idle_no_writes", 32'(wlog.size()), 32'd0);

    // Single burst on channel 2.
    chq[2].push_back(16'h0011);
    chq[2].push_back(16'h0022);
    chq[2].push_back(16'h0033);
    repeat (12) tick();
    e = '{16'hA002, 16'h0011, 16'h0022, 16'h0033, 16'hE003};
    expect_log("single", e);
    check("single_chsel", 32'(CHSEL),    32'd2);
    check("single_rr",    32'(dut.rr_q), 32'd3);
    check("single_idle",  32'(BUSY),     32'd0);

    // Return rr to 0.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst2_rr", 32'(dut.rr_q), 32'd0);

    // Fairness: channels 0 and 3 pending together, rr=0 -> channel 0 first.
    chq[0].push_back(16'h0100);
    chq[0].push_back(16'h0101);
    chq[3].push_back(16'h0300);
    repeat (20) tick();
    e = '{16'hA000, 16'h0100, 16'h0101, 16'hE002, 16'hA003, 16'h0300, 16'hE001};
    expect_log("fair", e);
    check("fair_rr", 32'(dut.rr_q), 32'd0);

    // Channel 0 still pending after a limited burst waits for channel 3.
    for (int k = 0; k < 5; k++) chq[0].push_back(16'h0110 + 16'(k));
    chq[3].push_back(16'h0310);
    repeat (40) tick();
    e = '{16'hA000, 16'h0110, 16'h0111, 16'h0112, 16'h0113, 16'hE004,
          16'hA003, 16'h0310, 16'hE001,
          16'hA000, 16'h0114, 16'hE001};
    expect_log("rerequest", e);
    check("rerequest_rr", 32'(dut.rr_q), 32'd1);

    // Burst limit: channel 1 with 10 words splits into 4 + 4 + 2.
    for (int k = 0; k < 10; k++) chq[1].push_back(16'h1000 + 16'(k));
    repeat (40) tick();
    e = {};
    for (int f = 0; f < 3; f++) begin
      e.push_back(16'hA001);
      for (int k = 0; k < ((f == 2) ? 2 : 4); k++) e.push_back(16'h1000 + 16'(f*4 + k));
      e.push_back((f == 2) ? 16'hE002 : 16'hE004);
    end
    expect_log("limit", e);
    check("limit_rr", 32'(dut.rr_q), 32'd2);

    // Backpressure mid-READ and during TRAILER on channel 2.
    chq[2].push_back(16'h0200);
    chq[2].push_back(16'h0201);
    chq[2].push_back(16'h0202);
    last_rd = '0;
    for (int k = 0; k < 20 && last_rd == '0; k++) tick();
    check("bp_first_pop", 32'(last_rd), 32'h4);
    FIFO_FULL = 1'b1;
    rd_acc = '0;
    repeat (5) begin
      tick();
      rd_acc |= last_rd;
    end
    check("bp_no_pop_full", 32'(rd_acc), 32'd0);
    FIFO_FULL = 1'b0;
    for (int k = 0; k < 20 && chq[2].size() != 0; k++) tick();
    check("bp_drained", 32'(chq[2].size()), 32'd0);
    FIFO_FULL = 1'b1;
    repeat (5) tick();
    check("bp_trailer_held", 32'(BUSY), 32'd1);
    FIFO_FULL = 1'b0;
    repeat (5) tick();
    e = '{16'hA002, 16'h0200, 16'h0201, 16'h0202, 16'hE003};
    expect_log("bp", e);
    check("bp_rr", 32'(dut.rr_q), 32'd3);

    // Reset in the middle of READ after two pops on channel 1.
    for (int k = 0; k < 4; k++) chq[1].push_back(16'h1100 + 16'(k));
    pops = 0;
    for (int k = 0; k < 30 && pops < 2; k++) begin
      tick();
      if (last_rd != '0) pops++;
    end
    check("mr_two_pops", 32'(pops), 32'd2);
    RST = 1'b1;
    #1;
    check("mr_rden_in_rst", 32'(CH_RDEN), 32'd0);
    tick();
    check("mr_busy",    32'(BUSY),     32'd0);
    check("mr_wr_en",   32'(WR_EN),    32'd0);
    check("mr_wr_data", 32'(WR_DATA),  32'd0);
    check("mr_chsel",   32'(CHSEL),    32'd0);
    check("mr_rr",      32'(dut.rr_q), 32'd0);
    e = '{16'hA001, 16'h1100, 16'h1101};
    expect_log("mr", e);
    RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_channel_arbiter.md
Name: ro_channel_arbiter

Overview:
- Round-robin scheduler that shares the single event-FIFO write port between NCH digitizer channel buffers.
- Per granted channel it frames one burst as header word, up to MAX_BURST data words, then trailer word.
- Sits between the per-channel show-ahead sample FIFOs and the shared output FIFO.
- Generalises the single-stream readout sequencer to multiple requesters with fairness and burst limiting.

Parameters:
- NCH, 4: number of channels; 2..16.
- DW, 16: data word width; must be at least 16.
- MAX_BURST, 64: max data words per grant; 1..4095.
- CH_W, 2: channel index width, equal to clog2(NCH); 1 is allowed when NCH=2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- DAVAIL  in  NCH  per-channel "show-ahead FIFO non-empty".
- CH_DATA  in  NCH*DW  per-channel head-of-FIFO word; channel i occupies bits [i*DW +: DW].
- CH_RDEN  out  NCH  one-hot pop strobe, combinational from state and inputs.
- FIFO_FULL  in  1  output FIFO full.
- WR_EN  out  1  registered write strobe to output FIFO.
- WR_DATA  out  DW  registered write data.
- CHSEL  out  CH_W  registered index of the granted channel.
- BUSY  out  1  registered; high in any state other than IDLE.

Behaviour:
- Reset values:
  - State IDLE; WR_EN=0; WR_DATA=0; CHSEL=0; BUSY=0; round-robin pointer rr=0; word count cnt=0.
  - CH_RDEN=0 whenever RST is high.
- States: IDLE, HEADER, READ, TRAILER.
- IDLE:
  - If any DAVAIL bit is set, grant g = first set bit searching upward from rr, wrapping modulo NCH.
  - Register CHSEL<=g, clear cnt, go to HEADER.
  - Otherwise remain in IDLE.
- HEADER:
  - If FIFO_FULL, hold the state; no write.
  - Else WR_EN<=1 and WR_DATA<={4'hA, 4'h0, 8-bit zero-extended CHSEL, zero pad to DW}, then go to READ.
- READ, pop condition P = DAVAIL[CHSEL] && !FIFO_FULL && cnt<MAX_BURST:
  - When P: CH_RDEN[CHSEL]=1 in the same cycle; at the edge WR_DATA<=CH_DATA[CHSEL], WR_EN<=1, cnt<=cnt+1.
  - Exit to TRAILER when !DAVAIL[CHSEL], or when cnt reaches MAX_BURST (evaluated with the post-increment count).
  - FIFO_FULL with DAVAIL[CHSEL] high: stall in READ; no pop, no write.
- TRAILER:
  - If FIFO_FULL, hold the state.
  - Else WR_EN<=1, WR_DATA<={4'hE, cnt[11:0]} zero-padded to DW, rr<=(CHSEL+1) mod NCH, go to IDLE.
- Latency:
  - A pop and its write are 1 cycle apart: the word appears on WR_DATA with WR_EN in the cycle after CH_RDEN.
  - Minimum IDLE-to-header write: 2 cycles.
- Strobes:
  - WR_EN defaults to 0 every cycle it is not explicitly set.
  - CH_RDEN is never asserted for a non-granted channel, and never while FIFO_FULL is high.
- Boundaries:
  - A burst with zero data words (DAVAIL drops before the first pop) still emits header plus trailer with count 0.
  - A channel that re-asserts DAVAIL while others are pending waits its round-robin turn.
  - DAVAIL for non-granted channels is ignored until IDLE.
  - RST asserted mid-burst returns to IDLE next edge with reset values; the partial frame is not terminated. Downstream detects it by the missing trailer.
- No illegal state is reachable; the default branch returns to IDLE.

Decomposition:
- Shared package ro_pkg holds:
  - HDR_MARK=4'hA and TRL_MARK=4'hE.
  - State encodings.
  - Header/trailer field positions.
- One sub-module, rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req[NCH], ptr[CH_W].
  - Outputs: idx[CH_W], valid.

Test Plan:
- Reset and idle: DAVAIL=0 for 20 cycles -> WR_EN, CH_RDEN and BUSY stay 0.
- Single burst: channel 2 holds 3 words 0x0011, 0x0022, 0x0033 -> writes 0xA002, 0x0011, 0x0022, 0x0033, 0xE003; CHSEL=2; rr becomes 3.
- Fairness: channels 0 and 3 both pending, rr=0 -> channel 0 frame first, then channel 3 frame. Re-requesting channel 0 is then served only after channel 3.
- Burst limit: MAX_BURST=4 with channel 1 holding 10 words -> 4 data words, trailer 0xE004, then IDLE and re-grant of channel 1 for the remainder.
- Backpressure: FIFO_FULL high for 5 cycles mid-READ and during TRAILER -> no CH_RDEN and no WR_EN while full; no words lost or duplicated.
- Reset mid-READ after 2 pops -> next cycle is IDLE, all outputs at reset values, rr=0.
